// File: rtl/mskaes_host_pkg.sv
// -----------------------------------------------------------------------------
// mskaes_host_pkg
//   Shared definitions for the masked AES-128 host front-end:
//     - state_e       : 3-bit FSM state encoding of mskaes_host_if
//     - BLOCK_W       : AES block width (bits)
//     - RND_W(d)      : mask bits needed to share one 128-bit block into d shares
//     - CNT_ALL_ONES  : all-ones saturation constant for the latency counter
//                       (sliced down to the counter width by the user)
// -----------------------------------------------------------------------------
package mskaes_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHARE  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_OUT    = 3'd4
    } state_e;

    localparam int BLOCK_W = 128;

    // Widest latency counter supported; CNT_W of the top must not exceed this.
    localparam int MAX_CNT_W = 64;
    localparam logic [MAX_CNT_W-1:0] CNT_ALL_ONES = '1;

    // Shares 0..d-2 of every bit are fresh randomness, share d-1 is derived.
    function automatic int RND_W(input int d);
        return BLOCK_W * (d - 1);
    endfunction

endpackage

// File: rtl/mskaes_share_codec.sv
// -----------------------------------------------------------------------------
// mskaes_share_codec
//   Combinational Boolean-masking codec with bit-interleaved share layout:
//   share j of bit i lives at index d*i + j.
//
//   DECODE = 0 (encoder):
//     data_i = {rnd, value}   rnd is width*(d-1) bits, value is width bits.
//                             Share j (j < d-1) of bit i is rnd[j*width + i];
//                             share d-1 is value[i] XOR those shares.
//     data_o = shares         width*d bits
//   DECODE = 1 (decoder):
//     data_i = shares         width*d bits
//     data_o = value          width bits, XOR of the d shares of each bit
//
// Ports
//   data_i  in   width*d             packed input (see above)
//   data_o  out  width*d or width    shares (encoder) / value (decoder)
// -----------------------------------------------------------------------------
module mskaes_share_codec #(
    parameter int d      = 2,
    parameter int width  = 128,
    parameter bit DECODE = 1'b0
) (
    input  logic [width*d-1:0]                        data_i,
    output logic [(DECODE ? width : width*d)-1:0]     data_o
);

    if (DECODE) begin : g_dec
        for (genvar i = 0; i < width; i++) begin : g_bit
            assign data_o[i] = ^data_i[d*i +: d];
        end
    end else begin : g_enc
        for (genvar i = 0; i < width; i++) begin : g_bit
            logic [d-2:0] r;
            for (genvar j = 0; j < d - 1; j++) begin : g_sh
                assign r[j] = data_i[width + j*width + i];
            end
            // r[0] lands on share 0, the derived share on share d-1.
            assign data_o[d*i +: d] = {data_i[i] ^ (^r), r};
        end
    end

endmodule

// File: rtl/mskaes_host_if.sv
// -----------------------------------------------------------------------------
// mskaes_host_if
//   Host front-end for the masked AES-128 core. Accepts an unmasked
//   plaintext/key pair, splits both into d Boolean shares using external
//   randomness, launches the core, measures the core latency and returns the
//   recombined (unmasked) ciphertext.
//
// Parameters
//   d      number of shares (>= 2)
//   CNT_W  latency counter width (<= MAX_CNT_W)
//
// Ports
//   clk, nrst             clock, asynchronous active-low reset
//   in_valid/in_ready     plaintext/key handshake
//   in_plaintext, in_key  unmasked 128-bit inputs
//   rnd                   2*RND_W(d) mask bits: low half plaintext, high half key
//   rnd_valid/rnd_ack     randomness handshake (one ack per accepted job)
//   core_valid_in         start pulse to the core (only while core_ready)
//   core_ready            core can start
//   core_sh_plaintext     128*d bit-interleaved plaintext shares
//   core_sh_key           128*d bit-interleaved key shares
//   core_cipher_valid     core result valid
//   core_sh_ciphertext    128*d bit-interleaved shared ciphertext
//   out_valid/out_ready   result handshake
//   out_ciphertext        recombined ciphertext
//   out_latency           rising edges from launch cycle to result cycle (saturating)
//   proto_err             sticky: core_cipher_valid seen outside WAIT
// -----------------------------------------------------------------------------
module mskaes_host_if
    import mskaes_host_pkg::*;
#(
    parameter int d     = 2,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     nrst,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BLOCK_W-1:0]       in_plaintext,
    input  logic [BLOCK_W-1:0]       in_key,

    input  logic [2*RND_W(d)-1:0]    rnd,
    input  logic                     rnd_valid,
    output logic                     rnd_ack,

    output logic                     core_valid_in,
    input  logic                     core_ready,
    output logic [BLOCK_W*d-1:0]     core_sh_plaintext,
    output logic [BLOCK_W*d-1:0]     core_sh_key,
    input  logic                     core_cipher_valid,
    input  logic [BLOCK_W*d-1:0]     core_sh_ciphertext,

    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BLOCK_W-1:0]       out_ciphertext,
    output logic [CNT_W-1:0]         out_latency,
    output logic                     proto_err
);

    localparam int RW = RND_W(d);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_ALL_ONES[CNT_W-1:0];

    state_e                 state_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic                   proto_err_q;
    logic [BLOCK_W-1:0]     pt_q;
    logic [BLOCK_W-1:0]     key_q;
    logic [BLOCK_W*d-1:0]   sh_pt_q;
    logic [BLOCK_W*d-1:0]   sh_key_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [BLOCK_W-1:0]     ct_q;
    logic [CNT_W-1:0]       lat_q;

    logic [BLOCK_W*d-1:0]   enc_pt;
    logic [BLOCK_W*d-1:0]   enc_key;
    logic [BLOCK_W-1:0]     ct_dec;

    // ------------------------------------------------------------------
    // Share encoders (plaintext, key) and ciphertext recombiner
    // ------------------------------------------------------------------
    mskaes_share_codec #(.d(d), .width(BLOCK_W), .DECODE(1'b0)) u_enc_pt (
        .data_i ({rnd[RW-1:0], pt_q}),
        .data_o (enc_pt)
    );

    mskaes_share_codec #(.d(d), .width(BLOCK_W), .DECODE(1'b0)) u_enc_key (
        .data_i ({rnd[2*RW-1:RW], key_q}),
        .data_o (enc_key)
    );

    mskaes_share_codec #(.d(d), .width(BLOCK_W), .DECODE(1'b1)) u_dec_ct (
        .data_i (core_sh_ciphertext),
        .data_o (ct_dec)
    );

    // ------------------------------------------------------------------
    // Saturating latency counter increment. The captured latency includes
    // the edge that closes the core_cipher_valid cycle, so a result in the
    // cycle right after launch reports 1.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q;
        if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with all datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            proto_err_q <= 1'b0;
            pt_q        <= '0;
            key_q       <= '0;
            sh_pt_q     <= '0;
            sh_key_q    <= '0;
            cnt_q       <= '0;
            ct_q        <= '0;
            lat_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the pre-edge register values regardless of statement order.
            if (core_cipher_valid && (state_q != ST_WAIT)) begin
                proto_err_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        pt_q       <= in_plaintext;
                        key_q      <= in_key;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_SHARE;
                    end
                end

                ST_SHARE: begin
                    if (rnd_valid) begin
                        sh_pt_q  <= enc_pt;
                        sh_key_q <= enc_key;
                        // Unmasked copies are not needed once shared.
                        pt_q     <= '0;
                        key_q    <= '0;
                        state_q  <= ST_LAUNCH;
                    end
                end

                ST_LAUNCH: begin
                    if (core_ready) begin
                        cnt_q   <= '0;
                        state_q <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    cnt_q <= cnt_d;
                    if (core_cipher_valid) begin
                        ct_q        <= ct_dec;
                        lat_q       <= cnt_d;
                        // Shares are only exposed while the core runs.
                        sh_pt_q     <= '0;
                        sh_key_q    <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end
                end

                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // The two consume/launch strobes must act in the same cycle as their
    // qualifying input, so they are decoded from the registered state.
    assign rnd_ack       = (state_q == ST_SHARE)  && rnd_valid;
    assign core_valid_in = (state_q == ST_LAUNCH) && core_ready;

    assign in_ready          = in_ready_q;
    assign out_valid         = out_valid_q;
    assign out_ciphertext    = ct_q;
    assign out_latency       = lat_q;
    assign proto_err         = proto_err_q;
    assign core_sh_plaintext = sh_pt_q;
    assign core_sh_key       = sh_key_q;

endmodule

// File: tb/tb_mskaes_host_if.sv
// -----------------------------------------------------------------------------
// tb_mskaes_host_if
//   Self-checking bench for mskaes_host_if (d=3, CNT_W=4) against a stub core
//   whose shared ciphertext is sh_pt XOR sh_key and whose latency is set per
//   job. Expected results are queued when a job is offered and popped when
//   out_valid appears.
// -----------------------------------------------------------------------------
module tb_mskaes_host_if;

    localparam int D      = 3;
    localparam int CNT_W  = 4;
    localparam int SH_W   = 128 * D;
    localparam int RND_T  = 2 * 128 * (D - 1);

    typedef struct {
        logic [127:0]     pt;
        logic [127:0]     key;
        int               lat;
        int               rnd_stall;
        int               ready_stall;
        int               bp;
        bit               poke_in;
        logic [127:0]     exp_ct;
        logic [CNT_W-1:0] exp_lat;
    } vec_t;

    typedef struct {
        logic [127:0]     ct;
        logic [CNT_W-1:0] lat;
    } exp_t;

    logic               clk;
    logic               nrst;
    logic               in_valid;
    logic               in_ready;
    logic [127:0]       in_plaintext;
    logic [127:0]       in_key;
    logic [RND_T-1:0]   rnd;
    logic               rnd_valid;
    logic               rnd_ack;
    logic               core_valid_in;
    logic               core_ready;
    logic [SH_W-1:0]    core_sh_plaintext;
    logic [SH_W-1:0]    core_sh_key;
    logic               core_cipher_valid;
    logic [SH_W-1:0]    core_sh_ciphertext;
    logic               out_valid;
    logic               out_ready;
    logic [127:0]       out_ciphertext;
    logic [CNT_W-1:0]   out_latency;
    logic               proto_err;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   cv_at    = 0;
    int   n_ack    = 0;
    int   n_launch = 0;
    int   n_accept = 0;
    int   stub_lat;
    int   stub_cnt;
    logic cv_force;

    exp_t sb_q[$];
    vec_t vecs[6];

    mskaes_host_if #(.d(D), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .nrst               (nrst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_plaintext       (in_plaintext),
        .in_key             (in_key),
        .rnd                (rnd),
        .rnd_valid          (rnd_valid),
        .rnd_ack            (rnd_ack),
        .core_valid_in      (core_valid_in),
        .core_ready         (core_ready),
        .core_sh_plaintext  (core_sh_plaintext),
        .core_sh_key        (core_sh_key),
        .core_cipher_valid  (core_cipher_valid),
        .core_sh_ciphertext (core_sh_ciphertext),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_ciphertext     (out_ciphertext),
        .out_latency        (out_latency),
        .proto_err          (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub core: result appears stub_lat rising edges after the launch cycle.
    always @(posedge clk or negedge nrst) begin
        if (!nrst)              stub_cnt <= 0;
        else if (core_valid_in) stub_cnt <= stub_lat;
        else if (stub_cnt != 0) stub_cnt <= stub_cnt - 1;
    end
    assign core_cipher_valid  = (stub_cnt == 1) || cv_force;
    assign core_sh_ciphertext = core_sh_plaintext ^ core_sh_key;

    // Event monitor.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rnd_ack)              n_ack    <= n_ack + 1;
        if (core_valid_in)        n_launch <= n_launch + 1;
        if (in_valid && in_ready) n_accept <= n_accept + 1;
        if (core_cipher_valid)    cv_at    <= cyc;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] share_slice(input logic [SH_W-1:0] s, input int j);
        logic [127:0] v;
        for (int i = 0; i < 128; i++) v[i] = s[D*i + j];
        return v;
    endfunction

    function automatic logic [127:0] recombine(input logic [SH_W-1:0] s);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 128; i++)
            for (int j = 0; j < D; j++) v[i] = v[i] ^ s[D*i + j];
        return v;
    endfunction

    function automatic logic [RND_T-1:0] fresh_rnd();
        logic [RND_T-1:0] r;
        for (int k = 0; k < RND_T / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Wait for out_valid, compare against the scoreboard, optionally hold
    // backpressure (with a stray in_valid), then complete the handshake.
    task automatic collect_result(input int bp, input bit poke);
        bit               ok;
        exp_t             e;
        logic [127:0]     ct_h;
        logic [CNT_W-1:0] lat_h;
        int               acc0;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            ok = out_valid;
        end
        check("out_valid_seen", {127'd0, ok}, 128'd1);
        if (!ok) return;
        check("out_valid_delay", cyc - cv_at, 1);
        if (sb_q.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
            return;
        end
        e = sb_q.pop_front();
        check("ciphertext", out_ciphertext, e.ct);
        check("latency", out_latency, e.lat);
        ct_h  = e.ct;
        lat_h = e.lat;
        acc0  = n_accept;
        in_valid     = poke;
        in_plaintext = 128'h0bad;
        for (int b = 0; b < bp; b++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_ct_stable", out_ciphertext, ct_h);
            check("bp_lat_stable", out_latency, lat_h);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("no_accept_during_out", n_accept - acc0, 0);
        check("post_hs_in_ready", in_ready, 1);
        check("post_hs_out_valid", out_valid, 0);
    endtask

    task automatic run_job(input vec_t v);
        logic [RND_T-1:0] r;
        int ack0, launch0, acc0;
        r       = fresh_rnd();
        ack0    = n_ack;
        launch0 = n_launch;
        acc0    = n_accept;
        @(negedge clk);
        in_plaintext = v.pt;
        in_key       = v.key;
        in_valid     = 1'b1;
        stub_lat     = v.lat;
        sb_q.push_back('{ct: v.exp_ct, lat: v.exp_lat});
        @(negedge clk);
        in_valid     = 1'b0;
        in_plaintext = '0;
        in_key       = '0;
        repeat (v.rnd_stall) @(negedge clk);
        rnd       = r;
        rnd_valid = 1'b1;
        @(negedge clk);
        rnd_valid = 1'b0;
        rnd       = '0;
        check("sh_pt_recombine", recombine(core_sh_plaintext), v.pt);
        check("sh_pt_share0", share_slice(core_sh_plaintext, 0), r[127:0]);
        check("sh_pt_share1", share_slice(core_sh_plaintext, 1), r[255:128]);
        check("sh_key_recombine", recombine(core_sh_key), v.key);
        check("sh_key_share0", share_slice(core_sh_key, 0), r[383:256]);
        repeat (v.ready_stall) @(negedge clk);
        core_ready = 1'b1;
        @(negedge clk);
        core_ready = 1'b0;
        collect_result(v.bp, v.poke_in);
        check("one_rnd_ack", n_ack - ack0, 1);
        check("one_launch", n_launch - launch0, 1);
        check("one_accept", n_accept - acc0, 1);
    endtask

    initial begin
        logic [RND_T-1:0] r;
        int               ack0;

        vecs[0] = '{pt: 128'h0123456789abcdef0123456789abcdef, key: 128'hffffffffffffffff0000000000000000,
                    lat: 7, rnd_stall: 0, ready_stall: 0, bp: 0, poke_in: 1'b0,
                    exp_ct: 128'hfedcba98765432100123456789abcdef, exp_lat: 4'd7};
        vecs[1] = '{pt: 128'h0, key: {128{1'b1}},
                    lat: 1, rnd_stall: 0, ready_stall: 0, bp: 0, poke_in: 1'b0,
                    exp_ct: {128{1'b1}}, exp_lat: 4'd1};
        vecs[2] = '{pt: 128'hdeadbeef00000000cafef00d12345678, key: 128'h00000000ffffffff0000ffff87654321,
                    lat: 7, rnd_stall: 5, ready_stall: 3, bp: 0, poke_in: 1'b0,
                    exp_ct: 128'hdeadbeefffffffffcafe0ff295511559, exp_lat: 4'd7};
        vecs[3] = '{pt: 128'h1, key: 128'h2,
                    lat: 20, rnd_stall: 1, ready_stall: 0, bp: 10, poke_in: 1'b1,
                    exp_ct: 128'h3, exp_lat: 4'd15};
        vecs[4] = '{pt: {128{1'b1}}, key: {128{1'b1}},
                    lat: 15, rnd_stall: 0, ready_stall: 1, bp: 2, poke_in: 1'b0,
                    exp_ct: 128'h0, exp_lat: 4'd15};
        vecs[5] = '{pt: 128'h80000000000000000000000000000000, key: 128'h0,
                    lat: 16, rnd_stall: 0, ready_stall: 0, bp: 0, poke_in: 1'b0,
                    exp_ct: 128'h80000000000000000000000000000000, exp_lat: 4'd15};

        nrst         = 1'b0;
        in_valid     = 1'b0;
        in_plaintext = '0;
        in_key       = '0;
        rnd          = '0;
        rnd_valid    = 1'b0;
        core_ready   = 1'b0;
        out_ready    = 1'b0;
        cv_force     = 1'b0;
        stub_lat     = 1;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_core_valid_in", core_valid_in, 0);
        check("rst_rnd_ack", rnd_ack, 0);
        check("rst_out_ciphertext", out_ciphertext, 0);
        check("rst_out_latency", out_latency, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_sh_pt", recombine(core_sh_plaintext) | share_slice(core_sh_plaintext, 0), 0);
        nrst = 1'b1;

        // rnd_valid while idle must not be acknowledged.
        rnd_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_rnd_ack", rnd_ack, 0);
        check("idle_ack_count", n_ack, 0);

        // ------- minimum latency: rnd_valid and core_ready already high -------
        r            = fresh_rnd();
        rnd          = r;
        core_ready   = 1'b1;
        stub_lat     = 3;
        in_plaintext = 128'h00112233445566778899aabbccddeeff;
        in_key       = 128'h000102030405060708090a0b0c0d0e0f;
        in_valid     = 1'b1;
        sb_q.push_back('{ct: 128'h00102030405060708090a0b0c0d0e0f0, lat: 4'd3});
        @(negedge clk);
        in_valid = 1'b0;
        check("fast_rnd_ack", rnd_ack, 1);
        check("fast_no_launch_yet", core_valid_in, 0);
        @(negedge clk);
        rnd_valid = 1'b0;
        check("fast_launch", core_valid_in, 1);
        check("fast_rnd_ack_once", rnd_ack, 0);
        @(negedge clk);
        core_ready = 1'b0;
        check("fast_launch_once", core_valid_in, 0);
        collect_result(0, 1'b0);

        // ---------------- table-driven jobs ----------------
        foreach (vecs[i]) run_job(vecs[i]);

        // ---------------- protocol error ----------------
        @(negedge clk);
        check("pre_proto_err", proto_err, 0);
        cv_force = 1'b1;
        @(negedge clk);
        cv_force = 1'b0;
        check("proto_err_set", proto_err, 1);
        check("proto_idle_in_ready", in_ready, 1);
        check("proto_idle_out_valid", out_valid, 0);
        repeat (5) @(negedge clk);
        check("proto_err_sticky", proto_err, 1);

        // ---------------- reset mid-WAIT ----------------
        ack0         = n_ack;
        stub_lat     = 12;
        in_plaintext = 128'h55;
        in_key       = 128'haa;
        in_valid     = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        rnd       = fresh_rnd();
        rnd_valid = 1'b1;
        @(negedge clk);
        rnd_valid  = 1'b0;
        core_ready = 1'b1;
        @(negedge clk);
        core_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("midwait_ack", n_ack - ack0, 1);
        check("midwait_in_ready", in_ready, 0);
        nrst = 1'b0;
        #1;
        check("mrst_in_ready", in_ready, 1);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_core_valid_in", core_valid_in, 0);
        check("mrst_proto_err", proto_err, 0);
        check("mrst_out_latency", out_latency, 0);
        check("mrst_out_ciphertext", out_ciphertext, 0);
        check("mrst_sh_key", share_slice(core_sh_key, 0), 0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (15) @(negedge clk);
        check("post_rst_no_result", out_valid, 0);
        check("post_rst_in_ready", in_ready, 1);

        // Recovery after reset.
        run_job(vecs[0]);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
